// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - round-robin command arbiter driving a shared JK flip-flop bank
//
// Purpose: N_REQ requesters issue hold/reset/set/toggle commands on a bit mask.
// One command per cycle is accepted round-robin and decoded into registered J/K
// vectors for an external JK bank. A shadow register mirrors the bank state.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   req_valid  in   [N_REQ]        per-requester command valid
//   req_ready  out  [N_REQ]        per-requester accept (combinational, one-hot or zero)
//   req_op     in   [2*N_REQ]      op per requester: 00 hold, 01 reset, 10 set, 11 toggle
//   req_mask   in   [WIDTH*N_REQ]  bit mask per requester
//   jk_j       out  [WIDTH]        registered J inputs to the bank
//   jk_k       out  [WIDTH]        registered K inputs to the bank
//   grant_vld  out                 jk_j/jk_k carry an accepted command
//   grant_id   out  [IDW]          requester owning the current jk_j/jk_k
//   shadow_q   out  [WIDTH]        mirror of bank Q
module jk_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_mask,
  output logic [WIDTH-1:0]       jk_j,
  output logic [WIDTH-1:0]       jk_k,
  output logic                   grant_vld,
  output logic [IDW-1:0]         grant_id,
  output logic [WIDTH-1:0]       shadow_q
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rr_ptr_d;
  logic [WIDTH-1:0] jk_j_q;
  logic [WIDTH-1:0] jk_k_q;
  logic             grant_vld_q;
  logic [IDW-1:0]   grant_id_q;

  logic             xfer;
  logic [IDW-1:0]   sel_id;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_mask;
  int               idx;
  int               nxt;

  // Scan from rr_ptr upward (wrapping); the first valid requester wins.
  always_comb begin
    req_ready = '0;
    xfer      = 1'b0;
    sel_id    = '0;
    sel_op    = '0;
    sel_mask  = '0;
    rr_ptr_d  = rr_ptr_q;
    idx       = 0;
    nxt       = 0;
    if (state_q == RUN) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = (int'(rr_ptr_q) + k) % N_REQ;
        if (!xfer && req_valid[idx]) begin
          xfer           = 1'b1;
          req_ready[idx] = 1'b1;
          sel_id         = idx[IDW-1:0];
          sel_op         = req_op[2*idx +: 2];
          sel_mask       = req_mask[WIDTH*idx +: WIDTH];
          nxt            = (idx + 1) % N_REQ;
          rr_ptr_d       = nxt[IDW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      rr_ptr_q    <= '0;
      jk_j_q      <= '0;
      jk_k_q      <= '0;
      grant_vld_q <= 1'b0;
      grant_id_q  <= '0;
      shadow_q    <= '0;
    end else begin
      // Track the bank: Q+ = J&~Q | ~K&Q.
      shadow_q <= (jk_j_q & ~shadow_q) | (~jk_k_q & shadow_q);
      case (state_q)
        CLEAR: begin
          // The bank has no reset of its own; K=all-ones forces it to zero.
          jk_j_q      <= '0;
          jk_k_q      <= '1;
          grant_vld_q <= 1'b0;
          state_q     <= RUN;
        end
        default: begin
          rr_ptr_q <= rr_ptr_d;
          if (xfer) begin
            jk_j_q      <= sel_mask & {WIDTH{sel_op[1]}};
            jk_k_q      <= sel_mask & {WIDTH{sel_op[0]}};
            grant_vld_q <= 1'b1;
            grant_id_q  <= sel_id;
          end else begin
            jk_j_q      <= '0;
            jk_k_q      <= '0;
            grant_vld_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign jk_j      = jk_j_q;
  assign jk_k      = jk_k_q;
  assign grant_vld = grant_vld_q;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - scoreboard bench for jk_bank_arbiter
module tb_jk_bank_arbiter;

  localparam int WIDTH = 8;
  localparam int N_REQ = 4;
  localparam int IDW   = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ-1:0]       req_ready;
  logic [2*N_REQ-1:0]     req_op = '0;
  logic [WIDTH*N_REQ-1:0] req_mask = '0;
  logic [WIDTH-1:0]       jk_j;
  logic [WIDTH-1:0]       jk_k;
  logic                   grant_vld;
  logic [IDW-1:0]         grant_id;
  logic [WIDTH-1:0]       shadow_q;

  jk_bank_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_mask(req_mask),
    .jk_j(jk_j), .jk_k(jk_k),
    .grant_vld(grant_vld), .grant_id(grant_id),
    .shadow_q(shadow_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] sh;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;

  // Reference state: round-robin pointer and bank contents after accepted commands.
  int               m_rr = 0;
  logic [WIDTH-1:0] m_sh = '0;
  int               last_g = -1;

  bit               mon_en = 1'b0;
  logic [WIDTH-1:0] mon_sh = '0;
  exp_t             e;

  logic [N_REQ-1:0]       cur_v;
  logic [2*N_REQ-1:0]     cur_op;
  logic [WIDTH*N_REQ-1:0] cur_mask;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of requests, predict the winner, check ready and queue the result.
  task automatic step(input logic [N_REQ-1:0] v, input logic [2*N_REQ-1:0] ops,
                      input logic [WIDTH*N_REQ-1:0] masks);
    int g;
    logic [1:0]       op;
    logic [WIDTH-1:0] mk;
    exp_t             x;
    req_valid = v;
    req_op    = ops;
    req_mask  = masks;
    @(negedge clk);
    g = -1;
    for (int i = 0; i < N_REQ; i++) begin
      if (g < 0 && v[(m_rr + i) % N_REQ]) g = (m_rr + i) % N_REQ;
    end
    chk("req_ready", req_ready, (g < 0) ? 0 : (64'd1 << g));
    if (g >= 0) begin
      op = ops[2*g +: 2];
      mk = masks[WIDTH*g +: WIDTH];
      x.id = g[IDW-1:0];
      case (op)
        2'b00: begin x.j = '0; x.k = '0; x.sh = m_sh;       end
        2'b01: begin x.j = '0; x.k = mk; x.sh = m_sh & ~mk; end
        2'b10: begin x.j = mk; x.k = '0; x.sh = m_sh | mk;  end
        default: begin x.j = mk; x.k = mk; x.sh = m_sh ^ mk; end
      endcase
      m_sh = x.sh;
      q.push_back(x);
      m_rr = (g + 1) % N_REQ;
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  // Release reset and check the CLEAR sequence; returns #1 after a posedge with monitor on.
  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = '1;
    @(negedge clk);
    chk("clear_ready", req_ready, 0);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    chk("clear_j", jk_j, 0);
    chk("clear_k", jk_k, 8'hFF);
    chk("clear_vld", grant_vld, 0);
    chk("clear_id", grant_id, 0);
    @(posedge clk);
    #1;
    mon_sh = '0;
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("shadow", shadow_q, mon_sh);
      if (grant_vld) begin
        if (q.size() == 0) begin
          chk("unexpected_grant", 1, 0);
        end else begin
          e = q.pop_front();
          chk("grant_id", grant_id, e.id);
          chk("jk_j", jk_j, e.j);
          chk("jk_k", jk_k, e.k);
          mon_sh = e.sh;
        end
      end else begin
        chk("idle_jk", {jk_j, jk_k}, 0);
      end
    end
  end

  task automatic random_phase(input int n);
    cur_v = '0;
    cur_op = '0;
    cur_mask = '0;
    last_g = -1;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        // A waiting requester must hold its command until accepted.
        if (!(cur_v[i] && last_g != i)) begin
          cur_v[i] = ($urandom_range(0, 99) < 55);
          cur_op[2*i +: 2] = 2'($urandom_range(0, 3));
          cur_mask[WIDTH*i +: WIDTH] = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
        end
      end
      step(cur_v, cur_op, cur_mask);
    end
  endtask

  initial begin
    #1;
    @(negedge clk);
    chk("rst_j", jk_j, 0);
    chk("rst_k", jk_k, 0);
    chk("rst_vld", grant_vld, 0);
    chk("rst_shadow", shadow_q, 0);
    chk("rst_ready", req_ready, 0);
    release_reset();

    // Req0 set 0F, then req1 toggle FF: shadow 0F then F0.
    step(4'b0001, 8'b00_00_00_10, {8'h00, 8'h00, 8'h00, 8'h0F});
    step(4'b0010, 8'b00_00_11_00, {8'h00, 8'h00, 8'hFF, 8'h00});
    step(4'b0000, '0, '0);
    step(4'b0000, '0, '0);
    chk("model_f0", m_sh, 8'hF0);
    // Bring rr_ptr back to 0, then all four continuously valid.
    step(4'b1000, 8'b01_00_00_00, {8'h03, 8'h00, 8'h00, 8'h00});
    for (int c = 0; c < 5; c++) step(4'b1111, 8'b11_10_01_00, {8'h81, 8'h42, 8'h24, 8'h18});
    // Only req2 valid for three cycles.
    for (int c = 0; c < 3; c++) step(4'b0100, 8'b00_10_00_00, {8'h00, 8'h10 << c, 8'h00, 8'h00});
    step(4'b0000, '0, '0);

    random_phase(300);

    // Reset while a grant is on the outputs.
    step(4'b0001, 8'b00_00_00_10, {8'h00, 8'h00, 8'h00, 8'hA5});
    chk("pre_rst_vld", grant_vld, 1);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    req_valid = '0;
    #1;
    chk("async_j", jk_j, 0);
    chk("async_k", jk_k, 0);
    chk("async_vld", grant_vld, 0);
    chk("async_shadow", shadow_q, 0);
    q.delete();
    m_rr = 0;
    m_sh = '0;
    @(posedge clk);
    release_reset();

    random_phase(200);
    for (int c = 0; c < 3; c++) step(4'b0000, '0, '0);
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
